instr_encoder: RTL

- Inverse of the immediate generator. Accepts decoded instruction fields (format, opcode, registers, functs, signed immediate) over a valid/ready stream.
- Range-checks the immediate, packs the fields into a 32-bit RV32I instruction word, and emits it with a sequential word address toward instruction-memory preload.
- Used by the program loader and by benches that build programs field-wise, so that encode→ImmGen round-trips can be checked.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/imm_pack.sv | 54 +++++
 rtl/instr_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcodes, error codes
// and the legal signed immediate range of each format.
package isa_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrFmt   = 2'd1,
    ErrRange = 2'd2,
    ErrAlign = 2'd3
  } err_code_t;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: builds the RV32I word for one decoded bundle and
// classifies why the bundle would be unencodable.
module imm_pack
  import isa_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output err_code_t   err_code_o
);

  fmt_t fmt;
  assign fmt = fmt_t'(fmt_i);

  always_comb begin
    instr_o    = '0;
    err_code_o = ErrNone;
    case (fmt)
      FmtR: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FmtI: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!imm_in_range(imm_i, IMM12_MIN, IMM12_MAX)) err_code_o = ErrRange;
      end
      FmtS: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!imm_in_range(imm_i, IMM12_MIN, IMM12_MAX)) err_code_o = ErrRange;
      end
      FmtB: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                   opcode_i};
        // Range is reported ahead of misalignment.
        if (!imm_in_range(imm_i, IMM_B_MIN, IMM_B_MAX)) err_code_o = ErrRange;
        else if (imm_i[0])                              err_code_o = ErrAlign;
      end
      FmtU: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'd0) err_code_o = ErrAlign;
      end
      FmtJ: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (!imm_in_range(imm_i, IMM_J_MIN, IMM_J_MAX)) err_code_o = ErrRange;
        else if (imm_i[0])                              err_code_o = ErrAlign;
      end
      default: err_code_o = ErrFmt;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Stream encoder: packs decoded field bundles into RV32I words, emits them with a
// sequential word address and stops with full after DEPTH words.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              full
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StHold  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  err_code_t         err_code_q, err_code_d;

  logic [31:0] pack_instr;
  err_code_t   pack_err;
  logic        last, fire, accept, legal;

  imm_pack u_imm_pack (
    .fmt_i      (in_fmt),
    .opcode_i   (in_opcode),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .imm_i      (in_imm),
    .instr_o    (pack_instr),
    .err_code_o (pack_err)
  );

  assign last      = (addr_q == ADDR_W'(DEPTH - 1));
  assign out_valid = (state_q == StHold);
  assign full      = (state_q == StFull);
  // A held word at the last index is the final one; accepting beside it would be lost.
  assign in_ready  = !full && (!out_valid || (out_ready && !last));
  assign fire      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign legal     = accept && (pack_err == ErrNone);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (fire && last)  state_d = StFull;
    else if (legal)    state_d = StHold;
    else if (fire)     state_d = StEmpty;

    if (legal)         instr_d = pack_instr;
    // Address saturates on the final word; full marks the end instead of a wrap.
    if (fire && !last) addr_d = addr_q + ADDR_W'(1);

    if (accept && (pack_err != ErrNone)) begin
      err_d      = 1'b1;
      err_code_d = pack_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      instr_q    <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
